// File: rtl/pipelined_addsub_if.sv
// Handshake and data bundle for pipelined_addsub: operation request side and result side.
// The master drives operations and consumes results; the slave is the adder itself.
interface pipelined_addsub_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_overflow;
    logic             out_zero;
    logic             out_neg;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_overflow, out_zero, out_neg, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_overflow, out_zero, out_neg, out_tag
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: stage k adds bit-slice k with the carry registered by stage k-1.
// Whole-pipeline stall on output back-pressure; flags are registered in the last stage.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 5
) (
    input logic            clk,
    input logic            rst,
    pipelined_addsub_if.slave bus
);
    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic              stall;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] cin;
    logic [WIDTH-1:0]  a_q    [STAGES];
    logic [WIDTH-1:0]  b_q    [STAGES];
    logic [WIDTH-1:0]  sum_q  [STAGES];
    logic [WIDTH-1:0]  a_d    [STAGES];
    logic [WIDTH-1:0]  b_d    [STAGES];
    logic [WIDTH-1:0]  sum_d  [STAGES];
    logic [WIDTH-1:0]  a_cur  [STAGES];
    logic [WIDTH-1:0]  b_cur  [STAGES];
    logic [WIDTH-1:0]  sum_in [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];
    logic [SW:0]       slice;
    logic              ovf_q, zero_q, neg_q;
    logic              ovf_d, zero_d, neg_d;

    assign stall        = vld_q[LAST] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Operands travel right-shifted so each stage always consumes the low slice of its input.
    always_comb begin
        a_cur[0]  = bus.in_a;
        b_cur[0]  = bus.in_sub ? ~bus.in_b : bus.in_b;
        cin[0]    = bus.in_sub;
        sum_in[0] = '0;
        tag_d[0]  = bus.in_tag;
        for (int k = 1; k < STAGES; k++) begin
            a_cur[k]  = a_q[k-1];
            b_cur[k]  = b_q[k-1];
            cin[k]    = c_q[k-1];
            sum_in[k] = sum_q[k-1];
            tag_d[k]  = tag_q[k-1];
        end
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_cur[k][SW-1:0]} + {1'b0, b_cur[k][SW-1:0]} + {{SW{1'b0}}, cin[k]};
            sum_d[k] = sum_in[k];
            sum_d[k][k*SW +: SW] = slice[SW-1:0];
            c_d[k] = slice[SW];
            a_d[k] = a_cur[k] >> SW;
            b_d[k] = b_cur[k] >> SW;
        end
        // In the last stage the top slice sits at the bottom, so the operand MSBs are at SW-1.
        ovf_d  = (a_cur[LAST][SW-1] == b_cur[LAST][SW-1]) &&
                 (sum_d[LAST][WIDTH-1] != a_cur[LAST][SW-1]);
        zero_d = (sum_d[LAST] == '0);
        neg_d  = sum_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else if (!stall) begin
            // in_ready is high whenever we advance, so in_valid alone marks a transfer.
            vld_q[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign bus.out_valid    = vld_q[LAST];
    assign bus.out_sum      = sum_q[LAST];
    assign bus.out_carry    = c_q[LAST];
    assign bus.out_overflow = ovf_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_neg      = neg_q;
    assign bus.out_tag      = tag_q[LAST];
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 32/4 stream checked against an arithmetic model every cycle,
// plus directed literal checks and 8-bit STAGES=1 / STAGES=8 corner cases.
module tb_pipelined_addsub;
    typedef struct packed {
        logic [31:0] sum;
        logic        c, v, z, n;
        logic [4:0]  tag;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_out  = 0;
    res_t exp_q[$];

    pipelined_addsub_if #(.WIDTH(32), .TAG_W(5)) a32 ();
    pipelined_addsub_if #(.WIDTH(8),  .TAG_W(5)) b1 ();
    pipelined_addsub_if #(.WIDTH(8),  .TAG_W(5)) b8 ();

    pipelined_addsub #(.WIDTH(32), .STAGES(4), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .bus(a32.slave));
    pipelined_addsub #(.WIDTH(8),  .STAGES(1), .TAG_W(5)) dut1  (.clk(clk), .rst(rst), .bus(b1.slave));
    pipelined_addsub #(.WIDTH(8),  .STAGES(8), .TAG_W(5)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Plain signed/unsigned arithmetic; carry for subtraction means "no borrow".
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                   input logic [4:0] tag);
        res_t   r;
        longint ua, ub, sa, sb, us, ss;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            us  = ua - ub;
            ss  = sa - sb;
            r.c = (ua >= ub);
        end else begin
            us  = ua + ub;
            ss  = sa + sb;
            r.c = (us > 64'sd4294967295);
        end
        r.sum = us[31:0];
        r.v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        r.z   = (r.sum == 32'd0);
        r.n   = r.sum[31];
        r.tag = tag;
        return r;
    endfunction

    // Compare process for the 32-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && a32.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL stream_unexpected actual sum=%h tag=%h required no result",
                             a32.out_sum, a32.out_tag);
                end else begin
                    chk("stream", {23'd0, a32.out_sum, a32.out_carry, a32.out_overflow,
                                   a32.out_zero, a32.out_neg, a32.out_tag}, {23'd0, exp_q[0]});
                    if (a32.out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (a32.in_valid === 1'b1 && a32.in_ready === 1'b1)
                exp_q.push_back(model(a32.in_a, a32.in_b, a32.in_sub, a32.in_tag));
            if (rst) exp_q.delete();
        end
    end

    task automatic accept32();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a32.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_tot++;
            $display("FAIL accept_timeout actual in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [4:0] tag, output int lat);
        a32.in_valid = 1'b1;
        a32.in_a     = a;
        a32.in_b     = b;
        a32.in_sub   = sub;
        a32.in_tag   = tag;
        accept32();
        a32.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (a32.out_valid) break;
        end
    endtask

    function automatic logic [3:0] flags32();
        return {a32.out_carry, a32.out_overflow, a32.out_zero, a32.out_neg};
    endfunction

    initial begin
        int          lat;
        int          n0;
        logic [41:0] snap;
        a32.in_valid = 1'b0; a32.in_a = '0; a32.in_b = '0; a32.in_sub = 1'b0; a32.in_tag = '0;
        a32.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.in_sub = 1'b0; b1.in_tag = '0;
        b1.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0; b8.in_sub = 1'b0; b8.in_tag = '0;
        b8.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", a32.out_valid, 0);
        chk("rst_in_ready", a32.in_ready, 1);
        chk("rst_sum", a32.out_sum, 0);
        chk("rst_flags_tag", {flags32(), a32.out_tag}, 0);
        chk("rst_8bit_valid", {b1.out_valid, b8.out_valid}, 0);

        @(posedge clk); #1;
        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'h03, lat);
        chk("wrap_latency", lat, 4);
        chk("wrap_sum", a32.out_sum, 32'h0000_0000);
        chk("wrap_flags_cvzn", flags32(), 4'b1010);
        chk("wrap_tag", a32.out_tag, 5'h03);

        @(posedge clk); #1;
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'h1A, lat);
        chk("ovf_latency", lat, 4);
        chk("ovf_sum", a32.out_sum, 32'h8000_0000);
        chk("ovf_flags_cvzn", flags32(), 4'b0101);
        chk("ovf_tag", a32.out_tag, 5'h1A);

        @(posedge clk); #1;
        op32(32'd5, 32'd7, 1'b1, 5'h01, lat);
        chk("sub5m7_sum", a32.out_sum, 32'hFFFF_FFFE);
        chk("sub5m7_flags_cvzn", flags32(), 4'b0001);
        @(posedge clk); #1;
        op32(32'd7, 32'd5, 1'b1, 5'h02, lat);
        chk("sub7m5_sum", a32.out_sum, 32'h0000_0002);
        chk("sub7m5_flags_cvzn", flags32(), 4'b1000);
        @(posedge clk); #1;
        op32(32'h8000_0000, 32'd1, 1'b1, 5'h04, lat);
        chk("submin_sum", a32.out_sum, 32'h7FFF_FFFF);
        chk("submin_flags_cvzn", flags32(), 4'b1100);

        // Back-to-back stream with a 3-cycle stall while the pipe is full.
        @(posedge clk); #1;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a32.in_valid = 1'b1;
                    a32.in_a     = $urandom;
                    a32.in_b     = $urandom;
                    a32.in_sub   = 1'($urandom_range(0, 1));
                    a32.in_tag   = 5'(i + 8);
                    accept32();
                end
                a32.in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (a32.out_valid) break;
                end
                @(posedge clk); #1;
                a32.out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready_0", a32.in_ready, 0);
                snap = {a32.out_valid, a32.out_sum, flags32(), a32.out_tag};
                for (int i = 1; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", a32.in_ready, 0);
                    chk("stall_hold", {a32.out_valid, a32.out_sum, flags32(), a32.out_tag}, snap);
                end
                @(posedge clk); #1;
                a32.out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("stream_count", n_out - n0, 8);

        // Reset with three in flight and a fourth presented during the reset cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            a32.in_valid = 1'b1;
            a32.in_a     = 32'(100 * (i + 1));
            a32.in_b     = 32'd3;
            a32.in_sub   = 1'b0;
            a32.in_tag   = 5'(i + 20);
            accept32();
        end
        a32.in_a = 32'd999;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a32.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", a32.out_valid, 0);
        chk("midrst_in_ready", a32.in_ready, 1);
        n0 = n_out;
        repeat (10) @(negedge clk);
        chk("midrst_none_emerge", n_out - n0, 0);
        @(posedge clk); #1;
        op32(32'h1234_5678, 32'h1111_1111, 1'b1, 5'h07, lat);
        chk("postrst_latency", lat, 4);
        chk("postrst_sum", a32.out_sum, 32'h0123_4567);
        chk("postrst_flags_cvzn", flags32(), 4'b1000);

        // WIDTH=8, STAGES=1.
        @(posedge clk); #1;
        b1.in_valid = 1'b1; b1.in_a = 8'h80; b1.in_b = 8'h01; b1.in_sub = 1'b1; b1.in_tag = 5'h09;
        @(negedge clk);
        chk("s1_in_ready", b1.in_ready, 1);
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (b1.out_valid) break;
        end
        chk("s1_latency", lat, 1);
        chk("s1_sum", b1.out_sum, 8'h7F);
        chk("s1_flags_cvzn", {b1.out_carry, b1.out_overflow, b1.out_zero, b1.out_neg}, 4'b1100);
        chk("s1_tag", b1.out_tag, 5'h09);

        // WIDTH=8, STAGES=8.
        @(posedge clk); #1;
        b8.in_valid = 1'b1; b8.in_a = 8'hFF; b8.in_b = 8'h01; b8.in_sub = 1'b0; b8.in_tag = 5'h11;
        @(negedge clk);
        chk("s8_in_ready", b8.in_ready, 1);
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (b8.out_valid) break;
        end
        chk("s8_latency", lat, 8);
        chk("s8_sum", b8.out_sum, 8'h00);
        chk("s8_flags_cvzn", {b8.out_carry, b8.out_overflow, b8.out_zero, b8.out_neg}, 4'b1010);
        chk("s8_tag", b8.out_tag, 5'h11);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined integer adder/subtractor for the datapath: the next generation of the team's fixed 32-bit combinational adder. Width, pipeline depth and tag width are generic. Add/sub is selected per operation. Carry, signed-overflow, zero and negative flags are produced. A valid/ready handshake supports back-pressure, so the block can sit between the ALU operand stage and writeback, or feed address-generation logic, without adding timing on long carry chains.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); stage k adds bit-slice k of width WIDTH/STAGES.
- TAG_W, 5, width of the sideband tag carried alongside each operation (e.g. destination register index).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_carry  out  1  carry out of MSB (for sub: 1 = no borrow).
- out_overflow  out  1  two's-complement signed overflow.
- out_zero  out  1  out_sum == 0.
- out_neg  out  1  out_sum[WIDTH-1].
- out_tag  out  TAG_W  tag of the operation.

## Operation
- Subtraction is computed as A + ~B with carry-in 1. Addition uses carry-in 0.
- Stage 0 registers the slice-0 sum, the slice-0 carry, the remaining upper operand slices, the sub bit and the tag.
- Stage k (1..STAGES-1) adds slice k using the registered carry from stage k-1. Lower result slices are delayed alongside.
- Flags are formed in the last stage from the full result.
  - out_overflow = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]), where B' is the effective (possibly inverted) B.
  - out_zero and out_neg derive from the full out_sum.
- Each stage has a valid bit.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Stall: stall = out_valid & ~out_ready.
  - When stalled, all stage registers and valid bits hold.
  - When not stalled, the pipeline advances one stage and stage-0 valid loads in_valid & in_ready.
- in_ready = ~stall. This is combinational from out_ready and the last-stage valid bit.
- Bubbles are not compressed. Ordering is strictly FIFO. No operation is dropped or duplicated.
- in_a, in_b, in_sub and in_tag are sampled only on an input transfer. Data on non-valid slots is don't-care but must not affect valid results.

## Timing
- Reset (rst high at a clock edge): all stage valid bits clear.
  - out_valid = 0 from the next cycle.
  - in_ready = 1 from the next cycle.
  - out_sum, flags and out_tag reset to 0.
- Reset mid-operation: all in-flight operations are discarded and none emerge afterwards. Reset overrides a simultaneous input transfer.
- Latency: with no stall, an operation accepted at edge N presents out_valid at edge N+STAGES-1 and is visible through the following cycle. This means latency is STAGES cycles from the accepting cycle. For STAGES=1 the result is registered and available the cycle after acceptance.
- Throughput: one operation per cycle while out_ready stays high.
- Simultaneous output transfer and input transfer in the same cycle are legal and required for full throughput.
- out_* remain stable while out_valid & ~out_ready.
- WIDTH=STAGES degenerates to a 1-bit-per-stage ripple. It must work without special-casing.

## Test plan
- WIDTH=32, STAGES=4: add 0xFFFFFFFF + 0x00000001 -> out_sum 0x00000000, carry 1, zero 1, overflow 0, neg 0, out_valid exactly 4 cycles after the accepting cycle.
- Add 0x7FFFFFFF + 0x00000001, tag 0x1A -> out_sum 0x80000000, overflow 1, neg 1, carry 0, out_tag 0x1A.
- Sub 5 - 7 -> 0xFFFFFFFE, carry 0, neg 1, overflow 0. Sub 7 - 5 -> 0x00000002, carry 1. Sub 0x80000000 - 1 -> 0x7FFFFFFF, overflow 1.
- Stream 8 back-to-back random ops; hold out_ready low for 3 cycles while the pipe is full -> in_ready low for those 3 cycles, outputs held stable, all 8 results emerge in order matching a reference model, no loss or duplication.
- Three operations in flight, assert rst for one cycle -> out_valid 0 and in_ready 1 on the next cycle, none of the three ever appears, and a new op afterwards returns its correct result with normal latency.
- WIDTH=8, STAGES=1: sub 0x80 - 0x01 -> 0x7F, overflow 1, carry 1, one-cycle latency. Also WIDTH=8, STAGES=8: 0xFF + 0x01 -> 0x00, carry 1 after 8 cycles.
